// File: rtl/mux_nto1_reg.sv
// Registered N:1 stream multiplexer with directed-select or round-robin grant.
// A single output pipeline register; input ready is combinational from the grant.
module mux_nto1_reg #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [SEL_W:0]   NumCh  = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LastCh = SEL_W'(N - 1);
  localparam logic [SEL_W-1:0] OneSel = SEL_W'(1);

  logic [W-1:0]     r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_can_accept;
  logic [SEL_W-1:0] w_grant;
  logic             w_grant_vld;
  logic [SEL_W:0]   w_idx;
  logic [W-1:0]     w_sel_data;
  logic             w_fire;

  assign w_can_accept = reset_n && (!r_out_valid || out_ready);

  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_idx       = '0;
    if (!mode) begin
      w_grant     = sel;
      w_grant_vld = ({1'b0, sel} < NumCh);
    end else begin
      // Cyclic search from the pointer; the wrap is at N, not 2**SEL_W.
      for (int unsigned i = 0; i < N; i++) begin
        w_idx = {1'b0, r_rr_ptr} + i[SEL_W:0];
        if (w_idx >= NumCh) w_idx = w_idx - NumCh;
        if (!w_grant_vld && in_valid[w_idx[SEL_W-1:0]]) begin
          w_grant     = w_idx[SEL_W-1:0];
          w_grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready   = '0;
    w_sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_grant_vld && (w_grant == k[SEL_W-1:0])) begin
        in_ready[k] = w_can_accept;
        w_sel_data  = in_data[k*W +: W];
      end
    end
  end

  assign w_fire = |(in_valid & in_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_fire) begin
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_grant;
        r_out_valid <= 1'b1;
        if (mode) r_rr_ptr <= (w_grant == LastCh) ? '0 : w_grant + OneSel;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg: an N=8 instance for the main flow and an
// N=5 instance for non-power-of-two select and round-robin wrap.
module tb_mux_nto1_reg;

  localparam int unsigned W = 8;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic [8*W-1:0] a_in_data;
  logic [7:0]     a_in_valid, a_in_ready;
  logic [2:0]     a_sel, a_out_sel;
  logic           a_mode, a_out_valid, a_out_ready;
  logic [W-1:0]   a_out_data;

  logic [5*W-1:0] b_in_data;
  logic [4:0]     b_in_valid, b_in_ready;
  logic [2:0]     b_sel, b_out_sel;
  logic           b_mode, b_out_valid, b_out_ready;
  logic [W-1:0]   b_out_data;

  int n_assert = 0;
  int n_fail   = 0;

  mux_nto1_reg #(.N(8), .W(W)) u_dut8 (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .sel       (a_sel),
    .mode      (a_mode),
    .out_data  (a_out_data),
    .out_sel   (a_out_sel),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  mux_nto1_reg #(.N(5), .W(W)) u_dut5 (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .sel       (b_sel),
    .mode      (b_mode),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] data, input logic [2:0] sel_exp);
    check_eq({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(a_out_data), 32'(data));
    check_eq({tag, "_sel"}, 32'(a_out_sel), 32'(sel_exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b1;
    a_mode      = 1'b0;
    a_sel       = '0;
    a_in_valid  = '0;
    a_out_ready = 1'b1;
    b_mode      = 1'b0;
    b_sel       = '0;
    b_in_valid  = '0;
    b_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) a_in_data[k*W +: W] = 8'h10 + 8'(k);
    for (int k = 0; k < 5; k++) b_in_data[k*W +: W] = 8'h50 + 8'(k);

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_data", 32'(a_out_data), 32'd0);
    check_eq("rst_sel", 32'(a_out_sel), 32'd0);
    a_in_valid = 8'hFF;
    a_sel      = 3'd3;
    b_in_valid = 5'h1F;
    #1;
    check_eq("rst_ready8", 32'(a_in_ready), 32'd0);
    check_eq("rst_ready5", 32'(b_in_ready), 32'd0);
    b_in_valid = '0;
    step();
    step();
    check_eq("rst_hold_valid", 32'(a_out_valid), 32'd0);
    #3 reset_n = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(a_in_ready), 32'h08);

    // Directed back-to-back, sel stepping every cycle
    for (int s = 0; s < 8; s++) begin
      a_sel = 3'(s);
      #1;
      check_eq("dir_ready", 32'(a_in_ready), 32'(8'h01 << s));
      step();
      check_a("dir", 8'h10 + 8'(s), 3'(s));
    end

    // Backpressure for 4 cycles, then drain and fill on one edge
    a_out_ready = 1'b0;
    a_sel       = 3'd2;
    #1;
    check_eq("bp_ready", 32'(a_in_ready), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check_a("bp_hold", 8'h17, 3'd7);
      check_eq("bp_ready_hold", 32'(a_in_ready), 32'd0);
    end
    a_out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(a_in_ready), 32'h04);
    step();
    check_a("bp_release", 8'h12, 3'd2);

    // Reset pulse mid-stream
    a_in_data[3*W +: W] = 8'hA5;
    a_sel = 3'd3;
    step();
    check_a("stream", 8'hA5, 3'd3);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(a_out_valid), 32'd0);
    check_eq("mid_rst_data", 32'(a_out_data), 32'd0);
    check_eq("mid_rst_sel", 32'(a_out_sel), 32'd0);
    check_eq("mid_rst_ready", 32'(a_in_ready), 32'd0);
    step();
    #2 reset_n = 1'b1;
    #1;
    check_eq("mid_rel_ready", 32'(a_in_ready), 32'h08);
    step();
    check_a("mid_rel", 8'hA5, 3'd3);
    a_in_data[3*W +: W] = 8'h13;

    // Round-robin fairness
    a_mode     = 1'b1;
    a_in_valid = 8'b1000_0101;
    #1;
    check_eq("rr_ready0", 32'(a_in_ready), 32'h01);
    for (int i = 0; i < 6; i++) begin
      logic [2:0] exp_sel;
      exp_sel = (i % 3 == 0) ? 3'd0 : ((i % 3 == 1) ? 3'd2 : 3'd7);
      step();
      check_a("rr", 8'h10 + 8'(exp_sel), exp_sel);
    end
    step();
    check_a("rr_pre_drop", 8'h10, 3'd0);
    a_in_valid = 8'h81;
    #1;
    check_eq("rr_drop_ready", 32'(a_in_ready), 32'h80);
    step();
    check_a("rr_skip", 8'h17, 3'd7);
    step();
    check_a("rr_after_skip", 8'h10, 3'd0);

    // Mode switch while stalled
    a_in_valid = 8'hFF;
    step();
    check_a("ms_fire1", 8'h11, 3'd1);
    a_out_ready = 1'b0;
    #1;
    check_eq("ms_stall_ready", 32'(a_in_ready), 32'd0);
    step();
    check_a("ms_stall", 8'h11, 3'd1);
    a_mode = 1'b0;
    a_sel  = 3'd5;
    #1;
    check_eq("ms_switch_ready", 32'(a_in_ready), 32'd0);
    a_out_ready = 1'b1;
    #1;
    check_eq("ms_release_ready", 32'(a_in_ready), 32'h20);
    step();
    check_a("ms_ch5", 8'h15, 3'd5);
    a_mode = 1'b1;
    #1;
    check_eq("ms_ptr_kept", 32'(a_in_ready), 32'h04);
    step();
    check_a("ms_rr_ch2", 8'h12, 3'd2);

    // N=5: out-of-range select and round-robin wrap
    b_in_valid = 5'h1F;
    b_sel      = 3'd6;
    #1;
    check_eq("n5_sel6_ready", 32'(b_in_ready), 32'd0);
    step();
    check_eq("n5_sel6_valid", 32'(b_out_valid), 32'd0);
    b_sel = 3'd5;
    #1;
    check_eq("n5_sel5_ready", 32'(b_in_ready), 32'd0);
    step();
    check_eq("n5_sel5_valid", 32'(b_out_valid), 32'd0);
    b_mode     = 1'b1;
    b_in_valid = 5'h10;
    #1;
    check_eq("n5_rr_ready4", 32'(b_in_ready), 32'h10);
    step();
    check_eq("n5_rr_sel4", 32'(b_out_sel), 32'd4);
    check_eq("n5_rr_data4", 32'(b_out_data), 32'h54);
    check_eq("n5_rr_valid4", 32'(b_out_valid), 32'd1);
    b_in_valid = 5'h12;
    #1;
    check_eq("n5_wrap_ready", 32'(b_in_ready), 32'h02);
    step();
    check_eq("n5_wrap_sel1", 32'(b_out_sel), 32'd1);
    b_in_valid = 5'h10;
    step();
    check_eq("n5_again_sel4", 32'(b_out_sel), 32'd4);
    step();
    check_eq("n5_repeat_sel4", 32'(b_out_sel), 32'd4);
    check_eq("n5_repeat_valid", 32'(b_out_valid), 32'd1);
    b_in_valid = 5'h11;
    #1;
    check_eq("n5_ptr_zero", 32'(b_in_ready), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_nto1_reg.md
Name: mux_nto1_reg

Overview:
- Parametrised, registered N:1 multiplexer. Successor to the combinational 8:1 bit mux.
- Generalised in channel count and data width.
- Each input channel and the output carry a valid/ready handshake.
- A mode input selects between host-directed select and round-robin arbitration.
- Sits between N producer streams and one consumer. Output is a single pipeline register with 1-cycle latency.

Parameters:
- N, 8, number of input channels (N >= 2; need not be a power of two)
- W, 8, data width per channel in bits
- SEL_W, $clog2(N), width of select and channel-id fields (derived; do not override)

Ports:
- clock  input  1  single clock; all state updates on posedge
- reset_n  input  1  asynchronous active-low reset
- in_data  input  N*W  channel k occupies bits [k*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- sel  input  SEL_W  channel select, used in mode 0
- mode  input  1  0 = directed select, 1 = round-robin
- out_data  output  W  registered selected data
- out_sel  output  SEL_W  registered index of the channel that supplied out_data
- out_valid  output  1  output register holds data
- out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-transfer):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready follows its combinational rule, so it is 0 for all channels while reset is held.
- can_accept = reset_n && (!out_valid || out_ready).
- Grant g (combinational, recomputed every cycle):
  - mode 0: g = sel. If sel >= N, there is no grant.
  - mode 1: g = first k with in_valid[k], searched cyclically starting at rr_ptr (rr_ptr, rr_ptr+1, ... wrapping to 0). No grant if in_valid is all zero.
- in_ready[k] = can_accept && (grant exists) && (k == g). All other bits are 0.
  - mode 0: in_ready[sel] may be 1 while in_valid[sel]=0.
  - mode 1: in_ready is only ever asserted toward a valid channel.
- fire = in_valid[g] && in_ready[g].
- Output register, at posedge:
  - if fire: out_data <= in_data[g], out_sel <= g, out_valid <= 1
  - else if out_ready: out_valid <= 0
  - out_data and out_sel hold while no fire occurs.
- rr_ptr advances only on a fire in mode 1: rr_ptr <= (g == N-1) ? 0 : g+1.
  - rr_ptr is frozen in mode 0 and on stalls.
- Latency: data presented at a fire edge appears on out_data after that edge, i.e. 1 cycle.
- Throughput: 1 transfer per cycle when out_ready is held high.
- Simultaneous drain and fill: out_valid=1, out_ready=1 and a fire in the same cycle gives out_valid staying 1 with the new data, no bubble.
- Backpressure: out_valid=1 with out_ready=0 drives in_ready to all zeros and leaves out_data/out_sel stable.
- Mode or sel changes take effect in the same cycle, since the grant is combinational. A change while stalled changes which channel will be taken next.
- Non-power-of-two N: sel values >= N never grant. The round-robin wrap uses N, not 2**SEL_W.
- Data integrity: no transfer is duplicated or dropped. Each fire produces exactly one out_valid && out_ready beat.

Test Plan:
- Reset mid-stream: N=8, W=8, mode 0, sel=3, in_data ch3=0xA5, stream running. Pulse reset_n low between edges -> out_valid drops to 0 immediately, out_data=0. After release, first fire gives out_data=0xA5, out_sel=3, exactly 1 cycle later.
- Directed back-to-back: mode 0, out_ready=1, sel stepping 0..7 on consecutive cycles, ch k data=0x10+k, all valid -> out_data sequence 0x10..0x17 one cycle behind sel, no bubbles.
- Backpressure: hold out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0x00, out_data stable. Release -> the pending beat drains and the next fire occurs on the same edge.
- Round-robin fairness: mode 1, in_valid=0b1000_0101, out_ready=1 -> out_sel sequence 0,2,7,0,2,7. Drop ch2 valid mid-sequence -> it is skipped, with no stall cycle.
- Wrap/edge: N=5 build, mode 0, sel=6 -> in_ready=0, no output. Mode 1, only ch4 valid -> out_sel=4, then rr_ptr wraps to 0 and ch4 is granted again next cycle.
- Mode switch while stalled: out_ready=0, mode 1 pointing at ch2. Switch to mode 0, sel=5, then release -> next beat comes from ch5, and rr_ptr is unchanged.
